// File: rtl/cdb_pkg.sv
// Shared CDB word format: constants and the tag/value packer.
// Latency: n/a (package only).
// Backpressure: n/a.
package cdb_pkg;

    localparam int CDB_W   = 64;
    localparam int TAG_W   = 16;
    localparam int VAL_W   = 32;
    localparam int TAG_LSB = 48;

    // One queued result as held in a source FIFO: {tag, value}.
    localparam int ENT_W   = TAG_W + VAL_W;

    // Word layout: [63:48]=tag, [47:32]=zero, [31:0]=value.
    function automatic logic [CDB_W-1:0] pack_cdb(input logic [TAG_W-1:0] tag,
                                                  input logic [VAL_W-1:0] value);
        return {tag, {(TAG_LSB - VAL_W){1'b0}}, value};
    endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source result FIFO, DEPTH x W, synchronous flush on rst.
// Latency: a pushed entry is visible on o_dat/!o_empty the cycle after the push edge.
// Backpressure: o_full is driven from the count alone; a same-cycle pop does not clear it.
//
// Ports: clk/rst       clock, synchronous active-high flush
//        i_push/i_dat  write request and data (ignored when full)
//        i_pop         read request (ignored when empty)
//        o_dat         head entry
//        o_full/o_empty occupancy flags
module cdb_src_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 48
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_dat,
    input  logic         i_pop,
    output logic [W-1:0] o_dat,
    output logic         o_full,
    output logic         o_empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_cnt;
    logic          w_push;
    logic          w_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_full  = (r_cnt == CW'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_dat   = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) r_wptr <= ptr_inc(r_wptr);
            if (w_pop)  r_rptr <= ptr_inc(r_rptr);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Storage needs no reset: the pointers/count define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_dat;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Gathers FU results into per-source FIFOs and issues up to two per cycle onto the dual CDB.
// Latency: accepted at edge t -> earliest write/write2 pulse registered at edge t+1.
// Backpressure: src_ready[i] = FIFO i not full; each bus pulses at most every other cycle.
//
// Ports: clk, rst                     clock, synchronous active-high reset
//        src_valid/src_tag/src_value  per-source result handshake (packed, source i at slice i)
//        src_ready                    per-source FIFO not full
//        data/write                   bus-0 word and one-cycle write pulse
//        data2/write2                 bus-1 word and one-cycle write pulse
//        bcast_count                  running count of pulses on both buses
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int N_SRC      = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_SRC-1:0]       src_valid,
    input  logic [TAG_W*N_SRC-1:0] src_tag,
    input  logic [VAL_W*N_SRC-1:0] src_value,
    output logic [N_SRC-1:0]       src_ready,
    output logic [CDB_W-1:0]       data,
    output logic                   write,
    output logic [CDB_W-1:0]       data2,
    output logic                   write2,
    output logic [31:0]            bcast_count
);

    localparam int IW = $clog2(N_SRC);

    logic [IW-1:0]    r_rr;
    logic [N_SRC-1:0] w_full;
    logic [N_SRC-1:0] w_empty;
    logic [N_SRC-1:0] w_pop;
    logic [ENT_W-1:0] w_head [N_SRC];

    logic             w_first_vld;
    logic [IW-1:0]    w_first_idx;
    logic             w_second_vld;
    logic [IW-1:0]    w_second_idx;
    logic             w_g0_vld;
    logic [IW-1:0]    w_g0_idx;
    logic             w_g1_vld;
    logic [IW-1:0]    w_g1_idx;
    logic [IW-1:0]    w_rr_nxt;

    // (base + off) mod N_SRC for off < N_SRC; N_SRC need not be a power of 2.
    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_SRC) s = s - N_SRC;
        return IW'(s);
    endfunction

    for (genvar i = 0; i < N_SRC; i++) begin : g_src
        cdb_src_fifo #(
            .DEPTH (FIFO_DEPTH),
            .W     (ENT_W)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .i_push  (src_valid[i]),
            .i_dat   ({src_tag[TAG_W*i +: TAG_W], src_value[VAL_W*i +: VAL_W]}),
            .i_pop   (w_pop[i]),
            .o_dat   (w_head[i]),
            .o_full  (w_full[i]),
            .o_empty (w_empty[i])
        );
    end

    assign src_ready = ~w_full;

    // Find the first two non-empty FIFOs in round-robin order from r_rr.
    always_comb begin
        w_first_vld  = 1'b0;
        w_first_idx  = '0;
        w_second_vld = 1'b0;
        w_second_idx = '0;
        for (int k = 0; k < N_SRC; k++) begin
            logic [IW-1:0] cand;
            cand = wrap_add(r_rr, k);
            if (!w_empty[cand]) begin
                if (!w_first_vld) begin
                    w_first_vld = 1'b1;
                    w_first_idx = cand;
                end else if (!w_second_vld) begin
                    w_second_vld = 1'b1;
                    w_second_idx = cand;
                end
            end
        end
    end

    // A bus is armed only when its write is low now, so every broadcast
    // is a fresh rising edge at the cdb. When bus 0 is busy, bus 1 gets
    // first pick rather than the second candidate.
    always_comb begin
        w_g0_vld = 1'b0;
        w_g0_idx = '0;
        w_g1_vld = 1'b0;
        w_g1_idx = '0;
        w_pop    = '0;
        if (!write) begin
            w_g0_vld = w_first_vld;
            w_g0_idx = w_first_idx;
            if (!write2) begin
                w_g1_vld = w_second_vld;
                w_g1_idx = w_second_idx;
            end
        end else if (!write2) begin
            w_g1_vld = w_first_vld;
            w_g1_idx = w_first_idx;
        end
        if (w_g0_vld) w_pop[w_g0_idx] = 1'b1;
        if (w_g1_vld) w_pop[w_g1_idx] = 1'b1;
    end

    // Pointer resumes just past the most recent grant (bus 1's when both fire).
    always_comb begin
        w_rr_nxt = r_rr;
        if (w_g1_vld)      w_rr_nxt = wrap_add(w_g1_idx, 1);
        else if (w_g0_vld) w_rr_nxt = wrap_add(w_g0_idx, 1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr        <= '0;
            data        <= '0;
            data2       <= '0;
            write       <= 1'b0;
            write2      <= 1'b0;
            bcast_count <= '0;
        end else begin
            r_rr   <= w_rr_nxt;
            write  <= w_g0_vld;
            write2 <= w_g1_vld;
            if (w_g0_vld) data  <= pack_cdb(w_head[w_g0_idx][ENT_W-1:VAL_W], w_head[w_g0_idx][VAL_W-1:0]);
            if (w_g1_vld) data2 <= pack_cdb(w_head[w_g1_idx][ENT_W-1:VAL_W], w_head[w_g1_idx][VAL_W-1:0]);
            bcast_count <= bcast_count + 32'(w_g0_vld) + 32'(w_g1_vld);
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter (N_SRC=4, FIFO_DEPTH=2) with hand-computed expectations.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: exercised by filling source 1 while both buses are mid-pulse.
module tb_cdb_arbiter;

    logic          clk;
    logic          rst;
    logic [3:0]    src_valid;
    logic [63:0]   src_tag;
    logic [127:0]  src_value;
    logic [3:0]    src_ready;
    logic [63:0]   data;
    logic          write;
    logic [63:0]   data2;
    logic          write2;
    logic [31:0]   bcast_count;

    int total;
    int bad;

    cdb_arbiter #(.N_SRC(4), .FIFO_DEPTH(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .src_valid   (src_valid),
        .src_tag     (src_tag),
        .src_value   (src_value),
        .src_ready   (src_ready),
        .data        (data),
        .write       (write),
        .data2       (data2),
        .write2      (write2),
        .bcast_count (bcast_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic [15:0] t, input logic [31:0] v);
        src_valid[i]          = 1'b1;
        src_tag[16*i +: 16]   = t;
        src_value[32*i +: 32] = v;
    endtask

    task automatic clr_src(input int i);
        src_valid[i] = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        int g0;
        int g3;
        logic prev_w;
        logic prev_w2;
        int consec;

        total     = 0;
        bad       = 0;
        src_valid = '0;
        src_tag   = '0;
        src_value = '0;
        rst       = 1'b0;

        // ---- reset then idle ----
        do_reset();
        check_val("rst_data",   data,        64'h0);
        check_val("rst_data2",  data2,       64'h0);
        check_val("rst_write",  {63'h0, write},  64'h0);
        check_val("rst_write2", {63'h0, write2}, 64'h0);
        check_val("rst_count",  {32'h0, bcast_count}, 64'h0);
        check_val("rst_ready",  {60'h0, src_ready},   64'hF);
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (write || write2) pulses++;
        end
        check_val("idle_pulses", 64'(pulses), 64'd0);

        // ---- single result on source 0 ----
        set_src(0, 16'h0005, 32'hDEADBEEF);
        step();                       // accepted
        clr_src(0);
        check_val("single_no_early", {63'h0, write}, 64'h0);
        step();                       // broadcast registered
        check_val("single_write",  {63'h0, write},  64'h1);
        check_val("single_data",   data,            64'h0005_0000_DEADBEEF);
        check_val("single_write2", {63'h0, write2}, 64'h0);
        check_val("single_count",  {32'h0, bcast_count}, 64'd1);
        step();
        check_val("single_pulse_end", {63'h0, write}, 64'h0);
        check_val("single_data_hold", data, 64'h0005_0000_DEADBEEF);

        // ---- four simultaneous results ----
        do_reset();
        set_src(0, 16'h0001, 32'd10);
        set_src(1, 16'h0002, 32'd20);
        set_src(2, 16'h0003, 32'd30);
        set_src(3, 16'h0004, 32'd40);
        step();                       // edge 0: all accepted
        src_valid = '0;
        step();                       // edge 1
        check_val("four_e1_w",  {62'h0, write, write2}, 64'h3);
        check_val("four_e1_d",  data,  64'h0001_0000_0000_000A);
        check_val("four_e1_d2", data2, 64'h0002_0000_0000_0014);
        step();                       // edge 2
        check_val("four_e2_w",  {62'h0, write, write2}, 64'h0);
        step();                       // edge 3
        check_val("four_e3_w",  {62'h0, write, write2}, 64'h3);
        check_val("four_e3_d",  data,  64'h0003_0000_0000_001E);
        check_val("four_e3_d2", data2, 64'h0004_0000_0000_0028);
        check_val("four_count", {32'h0, bcast_count}, 64'd4);

        // ---- back-pressure on source 1 ----
        do_reset();
        set_src(1, 16'h0100, 32'h1111_0000);   // moves RR pointer to 2
        step();
        clr_src(1);
        step();
        check_val("bp_pre_d", data, 64'h0100_0000_1111_0000);
        step();
        check_val("bp_pre_idle", {62'h0, write, write2}, 64'h0);
        set_src(2, 16'h0201, 32'h201);
        set_src(3, 16'h0301, 32'h301);
        set_src(0, 16'h0001, 32'h001);
        set_src(1, 16'h0101, 32'h101);
        step();                                 // b
        clr_src(2);
        clr_src(3);
        set_src(0, 16'h0002, 32'h002);
        set_src(1, 16'h0102, 32'h102);
        step();                                 // b+1
        check_val("bp_b1_w",     {62'h0, write, write2}, 64'h3);
        check_val("bp_b1_d",     data,  64'h0201_0000_0000_0201);
        check_val("bp_b1_d2",    data2, 64'h0301_0000_0000_0301);
        check_val("bp_b1_ready", {60'h0, src_ready}, 64'hC);
        clr_src(0);
        set_src(1, 16'h0103, 32'h103);          // held until accepted
        step();                                 // b+2: full + pop pending keeps ready low
        check_val("bp_b2_w",     {62'h0, write, write2}, 64'h0);
        check_val("bp_b2_ready", {60'h0, src_ready}, 64'hC);
        step();                                 // b+3
        check_val("bp_b3_d",     data,  64'h0001_0000_0000_0001);
        check_val("bp_b3_d2",    data2, 64'h0101_0000_0000_0101);
        check_val("bp_b3_ready", {60'h0, src_ready}, 64'hF);
        step();                                 // b+4: third src1 result accepted
        clr_src(1);
        check_val("bp_b4_ready", {60'h0, src_ready}, 64'hD);
        step();                                 // b+5
        check_val("bp_b5_d",     data,  64'h0002_0000_0000_0002);
        check_val("bp_b5_d2",    data2, 64'h0102_0000_0000_0102);
        step();                                 // b+6
        step();                                 // b+7
        check_val("bp_b7_w",     {62'h0, write, write2}, 64'h2);
        check_val("bp_b7_d",     data,  64'h0103_0000_0000_0103);
        check_val("bp_count",    {32'h0, bcast_count}, 64'd8);

        // ---- round-robin fairness, sources 0 and 3 ----
        do_reset();
        g0 = 0;
        g3 = 0;
        consec  = 0;
        prev_w  = 1'b0;
        prev_w2 = 1'b0;
        set_src(0, 16'h0A0A, 32'h0000_00A0);
        set_src(3, 16'h0D0D, 32'h0000_00D0);
        for (int c = 0; c < 30; c++) begin
            step();
            if (c == 19) src_valid = '0;
            if (write) begin
                if (data[63:48] == 16'h0A0A) g0++;
                if (data[63:48] == 16'h0D0D) g3++;
            end
            if (write2) begin
                if (data2[63:48] == 16'h0A0A) g0++;
                if (data2[63:48] == 16'h0D0D) g3++;
            end
            if ((write && prev_w) || (write2 && prev_w2)) consec++;
            prev_w  = write;
            prev_w2 = write2;
        end
        check_val("rr_src0_grants", 64'(g0), 64'd11);
        check_val("rr_src3_grants", 64'(g3), 64'd11);
        check_val("rr_balance", 64'((g0 - g3 <= 1) && (g3 - g0 <= 1)), 64'd1);
        check_val("rr_no_consec", 64'(consec), 64'd0);
        check_val("rr_count", {32'h0, bcast_count}, 64'd22);

        // ---- reset with results queued ----
        set_src(0, 16'h0E00, 32'hE0);
        set_src(1, 16'h0E01, 32'hE1);
        set_src(2, 16'h0E02, 32'hE2);
        step();                                 // three results now queued
        src_valid = '0;
        rst = 1'b1;
        check_val("mid_pre_w", {62'h0, write, write2}, 64'h0);
        step();                                 // reset edge
        rst = 1'b0;
        check_val("mid_rst_w",     {62'h0, write, write2}, 64'h0);
        check_val("mid_rst_count", {32'h0, bcast_count}, 64'd0);
        check_val("mid_rst_ready", {60'h0, src_ready}, 64'hF);
        step();
        check_val("mid_after_w",   {62'h0, write, write2}, 64'h0);
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (write || write2) pulses++;
        end
        check_val("mid_no_pulses", 64'(pulses), 64'd0);
        check_val("mid_count",     {32'h0, bcast_count}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
